// File: rtl/lsu_pkg.sv
// Shared definitions for the NPC load/store unit: funct3 codes, FSM states,
// size masks and the legality/alignment check used at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return MASK_B;
            2'd1:    return MASK_H;
            2'd2:    return MASK_W;
            default: return MASK_D;
        endcase
    endfunction

    // Legal funct3 for the direction and address a multiple of the access size.
    function automatic logic op_ok(input logic we, input logic [2:0] funct3,
                                   input logic [2:0] off);
        logic legal;
        logic aligned;
        if (we)
            legal = funct3 inside {F3_B, F3_H, F3_W, F3_D};
        else
            legal = funct3 inside {F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU};
        case (funct3[1:0])
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = (off[0] == 1'b0);
            2'd2:    aligned = (off[1:0] == 2'b00);
            default: aligned = (off == 3'b000);
        endcase
        return legal && aligned;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-stage request channel and 64-bit data-memory port of the LSU.
interface lsu_req_if #(
    parameter int DW = 64,
    parameter int AW = 5
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [DW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [AW-1:0] req_rd;

    modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
                    input  req_ready);
    modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
                    output req_ready);
endinterface

interface lsu_mem_if #(
    parameter int DW = 64
);
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [7:0]    mem_wmask;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rdata;

    modport master (output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
                    input  mem_req_ready, mem_rsp_valid, mem_rdata);
    modport slave  (input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
                    output mem_req_ready, mem_rsp_valid, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/mask placement and load extraction with
// sign/zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [2:0]    funct3,
    input  logic [2:0]    off,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] st_wdata,
    output logic [7:0]    st_wmask,
    output logic [DW-1:0] ld_data
);
    logic [5:0]    shamt;
    logic [DW-1:0] shifted;

    always_comb begin
        shamt    = {off, 3'b000};
        st_wdata = wdata << shamt;
        st_wmask = size_mask(funct3[1:0]) << off;
        shifted  = rdata >> shamt;
        case (funct3)
            F3_B:    ld_data = {{(DW-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data = {{(DW-8){1'b0}}, shifted[7:0]};
            F3_H:    ld_data = {{(DW-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data = {{(DW-16){1'b0}}, shifted[15:0]};
            F3_W:    ld_data = {{(DW-32){shifted[31]}}, shifted[31:0]};
            F3_WU:   ld_data = {{(DW-32){1'b0}}, shifted[31:0]};
            F3_D:    ld_data = shifted;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// NPC load/store unit: one operation in flight, valid/ready memory request,
// load result delivered on the register-file write-back port.
module lsu
    import lsu_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rstn,
    lsu_req_if.slave      req,
    lsu_mem_if.master     mem,
    output logic          wb_en,
    output logic          wb_load,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] load_data,
    output logic          done,
    output logic          err_misalign
);
    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [2:0]    off_q, off_d;
    logic [DW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]    mem_wmask_q, mem_wmask_d;
    logic [AW-1:0] wb_addr_q, wb_addr_d;
    logic [DW-1:0] load_data_q, load_data_d;

    logic [2:0]    sel_funct3, sel_off;
    logic [DW-1:0] st_wdata, ld_data;
    logic [7:0]    st_wmask;

    // The single aligner serves the live request in IDLE and the latched op afterwards.
    assign sel_funct3 = (state_q == S_IDLE) ? req.req_funct3 : funct3_q;
    assign sel_off    = (state_q == S_IDLE) ? req.req_addr[2:0] : off_q;

    lsu_align #(.DW(DW)) u_align (
        .funct3   (sel_funct3),
        .off      (sel_off),
        .wdata    (req.req_wdata),
        .rdata    (mem.mem_rdata),
        .st_wdata (st_wdata),
        .st_wmask (st_wmask),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        wb_addr_d   = wb_addr_q;
        load_data_d = load_data_q;
        case (state_q)
            S_IDLE: begin
                if (req.req_valid) begin
                    we_d        = req.req_we;
                    funct3_d    = req.req_funct3;
                    off_d       = req.req_addr[2:0];
                    mem_addr_d  = {req.req_addr[DW-1:3], 3'b000};
                    mem_wdata_d = st_wdata;
                    mem_wmask_d = req.req_we ? st_wmask : '0;
                    wb_addr_d   = req.req_rd;
                    state_d     = op_ok(req.req_we, req.req_funct3, req.req_addr[2:0])
                                  ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                if (mem.mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem.mem_rsp_valid) begin
                    if (!we_q) load_data_d = ld_data;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            wb_addr_q   <= '0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            wb_addr_q   <= wb_addr_d;
            load_data_q <= load_data_d;
        end
    end

    assign req.req_ready     = (state_q == S_IDLE);
    assign mem.mem_req_valid = (state_q == S_REQ);
    assign mem.mem_we        = we_q;
    assign mem.mem_addr      = mem_addr_q;
    assign mem.mem_wdata     = mem_wdata_q;
    assign mem.mem_wmask     = mem_wmask_q;
    assign wb_en             = (state_q == S_DONE) && !we_q;
    assign wb_load           = (state_q == S_DONE) && !we_q;
    assign wb_addr           = wb_addr_q;
    assign load_data         = load_data_q;
    assign done              = (state_q == S_DONE) || (state_q == S_ERR);
    assign err_misalign      = (state_q == S_ERR);

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, multi-cycle corner
// sequences and randomized ops against a byte-level reference model.
module tb_lsu;

    logic        clk;
    logic        rstn;
    logic        wb_en, wb_load, done, err_misalign;
    logic [4:0]  wb_addr;
    logic [63:0] load_data;
    logic [63:0] last_ld;
    int          n_tests;
    int          n_fail;

    lsu_req_if #(.DW(64), .AW(5)) req_if ();
    lsu_mem_if #(.DW(64))         mem_if ();

    lsu #(.DW(64), .AW(5)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req          (req_if),
        .mem          (mem_if),
        .wb_en        (wb_en),
        .wb_load      (wb_load),
        .wb_addr      (wb_addr),
        .load_data    (load_data),
        .done         (done),
        .err_misalign (err_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        exp_err;
        logic [63:0] exp_ld;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-level rules, independent of any lane-shift structure.
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [63:0] addr);
        logic legal;
        legal = we ? (f3 < 4) : (f3 != 7);
        return !legal || ((int'(addr[2:0]) % m_size(f3)) != 0);
    endfunction

    function automatic logic [7:0] m_wmask(input logic [2:0] f3, input logic [63:0] addr);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < m_size(f3); i++) m[int'(addr[2:0]) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] addr,
                                           input logic [63:0] rdata);
        logic [63:0] val;
        int          sz;
        int          off;
        sz  = m_size(f3);
        off = int'(addr[2:0]);
        val = '0;
        for (int i = 0; i < sz; i++)
            val = val | (64'(rdata[8*(off+i) +: 8]) << (8*i));
        if (f3 < 4 && sz < 8 && val[8*sz-1])
            val = val | ~((64'd1 << (8*sz)) - 64'd1);
        return val;
    endfunction

    function automatic vec_t make_vec(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                                      input logic [63:0] wdata, input logic [63:0] rdata,
                                      input logic [4:0] rd);
        vec_t v;
        v.we        = we;
        v.f3        = f3;
        v.addr      = addr;
        v.wdata     = wdata;
        v.rdata     = rdata;
        v.rd        = rd;
        v.exp_err   = m_err(we, f3, addr);
        v.exp_ld    = m_load(f3, addr, rdata);
        v.exp_wmask = we ? m_wmask(f3, addr) : 8'h00;
        v.exp_wdata = wdata << (8 * int'(addr[2:0]));
        return v;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        req_if.req_valid     = 1'b0;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        @(negedge clk);
        rstn    = 1'b1;
        last_ld = '0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_ready"}, req_if.req_ready, 1);
        chk({tag, "_mem_req_valid"}, mem_if.mem_req_valid, 0);
        chk({tag, "_mem_we"}, mem_if.mem_we, 0);
        chk({tag, "_mem_addr"}, mem_if.mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_if.mem_wdata, 0);
        chk({tag, "_mem_wmask"}, mem_if.mem_wmask, 0);
        chk({tag, "_wb_en"}, wb_en, 0);
        chk({tag, "_wb_load"}, wb_load, 0);
        chk({tag, "_wb_addr"}, wb_addr, 0);
        chk({tag, "_load_data"}, load_data, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err_misalign, 0);
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge after completion.
    task automatic do_op(input vec_t v, input int rdy_dly, input int rsp_dly);
        logic [63:0] ea;
        ea = {v.addr[63:3], 3'b000};
        chk("idle_req_ready", req_if.req_ready, 1);
        req_if.req_valid  = 1'b1;
        req_if.req_we     = v.we;
        req_if.req_funct3 = v.f3;
        req_if.req_addr   = v.addr;
        req_if.req_wdata  = v.wdata;
        req_if.req_rd     = v.rd;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        req_if.req_addr  = {$urandom, $urandom};
        req_if.req_wdata = {$urandom, $urandom};
        req_if.req_rd    = 5'($urandom);
        if (v.exp_err) begin
            chk("err_done", done, 1);
            chk("err_flag", err_misalign, 1);
            chk("err_mem_req_valid", mem_if.mem_req_valid, 0);
            chk("err_wb_en", wb_en, 0);
            chk("err_req_ready", req_if.req_ready, 0);
            @(negedge clk);
            chk("err_done_clear", done, 0);
            chk("err_flag_clear", err_misalign, 0);
            chk("err_mem_req_valid_after", mem_if.mem_req_valid, 0);
            chk("err_load_data_kept", load_data, last_ld);
        end else begin
            for (int c = 0; c <= rdy_dly; c++) begin
                chk("req_mem_req_valid", mem_if.mem_req_valid, 1);
                chk("req_mem_addr", mem_if.mem_addr, ea);
                chk("req_mem_we", mem_if.mem_we, v.we);
                chk("req_mem_wmask", mem_if.mem_wmask, v.exp_wmask);
                if (v.we) chk("req_mem_wdata", mem_if.mem_wdata, v.exp_wdata);
                chk("req_req_ready", req_if.req_ready, 0);
                chk("req_done", done, 0);
                if (c == rdy_dly) begin
                    mem_if.mem_req_ready = 1'b1;
                    mem_if.mem_rsp_valid = 1'b0;
                end else begin
                    mem_if.mem_rsp_valid = (c % 2 == 0);
                    mem_if.mem_rdata     = {$urandom, $urandom};
                end
                @(negedge clk);
            end
            mem_if.mem_req_ready = 1'b0;
            for (int c = 0; c <= rsp_dly; c++) begin
                chk("wait_mem_req_valid", mem_if.mem_req_valid, 0);
                chk("wait_done", done, 0);
                chk("wait_req_ready", req_if.req_ready, 0);
                if (c == rsp_dly) begin
                    mem_if.mem_rsp_valid = 1'b1;
                    mem_if.mem_rdata     = v.rdata;
                end
                @(negedge clk);
            end
            mem_if.mem_rsp_valid = 1'b0;
            mem_if.mem_rdata     = {$urandom, $urandom};
            chk("done_pulse", done, 1);
            chk("done_err", err_misalign, 0);
            chk("done_wb_en", wb_en, !v.we);
            chk("done_wb_load", wb_load, !v.we);
            chk("done_req_ready", req_if.req_ready, 0);
            chk("done_mem_req_valid", mem_if.mem_req_valid, 0);
            if (!v.we) begin
                chk("done_wb_addr", wb_addr, v.rd);
                chk("done_load_data", load_data, v.exp_ld);
                last_ld = v.exp_ld;
            end else begin
                chk("done_load_data_kept", load_data, last_ld);
            end
            @(negedge clk);
            chk("after_done", done, 0);
            chk("after_wb_en", wb_en, 0);
        end
        chk("after_req_ready", req_if.req_ready, 1);
        if (req_if.req_ready !== 1'b1) do_reset();
    endtask

    localparam logic [63:0] RD = 64'h8877_6655_4433_2211;
    vec_t tbl[17];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        last_ld = '0;
        rstn = 1'b0;
        req_if.req_valid     = 1'b0;
        req_if.req_we        = 1'b0;
        req_if.req_funct3    = '0;
        req_if.req_addr      = '0;
        req_if.req_wdata     = '0;
        req_if.req_rd        = '0;
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_rsp_valid = 1'b0;
        mem_if.mem_rdata     = '0;

        //            we  f3      addr                  wdata                  rdata  rd     err ld                      wmask  wdata
        tbl[0]  = '{1'b0, 3'b000, 64'h0000_0000_0000_1003, 64'h0, RD, 5'd5,  1'b0, 64'h0000_0000_0000_0044, 8'h00, 64'h0};
        tbl[1]  = '{1'b0, 3'b000, 64'h0000_0000_0000_1007, 64'h0, RD, 5'd6,  1'b0, 64'hFFFF_FFFF_FFFF_FF88, 8'h00, 64'h0};
        tbl[2]  = '{1'b0, 3'b100, 64'h0000_0000_0000_1007, 64'h0, RD, 5'd7,  1'b0, 64'h0000_0000_0000_0088, 8'h00, 64'h0};
        tbl[3]  = '{1'b1, 3'b001, 64'h0000_0000_0000_0006, 64'hABCD, RD, 5'd1, 1'b0, 64'h0, 8'hC0, 64'hABCD_0000_0000_0000};
        tbl[4]  = '{1'b0, 3'b010, 64'h0000_0000_0000_0002, 64'h0, RD, 5'd2,  1'b1, 64'h0, 8'h00, 64'h0};
        tbl[5]  = '{1'b0, 3'b111, 64'h0000_0000_0000_0000, 64'h0, RD, 5'd3,  1'b1, 64'h0, 8'h00, 64'h0};
        tbl[6]  = '{1'b0, 3'b001, 64'h0000_0000_0000_1002, 64'h0, RD, 5'd0,  1'b0, 64'h0000_0000_0000_4433, 8'h00, 64'h0};
        tbl[7]  = '{1'b0, 3'b001, 64'h0000_0000_0000_1006, 64'h0, RD, 5'd8,  1'b0, 64'hFFFF_FFFF_FFFF_8877, 8'h00, 64'h0};
        tbl[8]  = '{1'b0, 3'b101, 64'h0000_0000_0000_1006, 64'h0, RD, 5'd9,  1'b0, 64'h0000_0000_0000_8877, 8'h00, 64'h0};
        tbl[9]  = '{1'b0, 3'b010, 64'h0000_0000_0000_1004, 64'h0, RD, 5'd10, 1'b0, 64'hFFFF_FFFF_8877_6655, 8'h00, 64'h0};
        tbl[10] = '{1'b0, 3'b110, 64'h0000_0000_0000_1004, 64'h0, RD, 5'd11, 1'b0, 64'h0000_0000_8877_6655, 8'h00, 64'h0};
        tbl[11] = '{1'b1, 3'b000, 64'h0000_0000_0000_0005, 64'h7F, RD, 5'd12, 1'b0, 64'h0, 8'h20, 64'h0000_7F00_0000_0000};
        tbl[12] = '{1'b1, 3'b010, 64'h0000_0000_0000_0006, 64'h1234, RD, 5'd13, 1'b1, 64'h0, 8'h00, 64'h0};
        tbl[13] = '{1'b1, 3'b100, 64'h0000_0000_0000_0008, 64'h1234, RD, 5'd14, 1'b1, 64'h0, 8'h00, 64'h0};
        tbl[14] = '{1'b0, 3'b011, 64'h0000_0000_0000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd17,
                    1'b0, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0};
        tbl[15] = '{1'b1, 3'b011, 64'h0000_0000_0000_0010, 64'hDEAD_BEEF_CAFE_F00D, RD, 5'd18,
                    1'b0, 64'h0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D};
        tbl[16] = '{1'b1, 3'b010, 64'h0000_0000_0000_001C, 64'h1122_3344_5566_7788, RD, 5'd19,
                    1'b0, 64'h0, 8'hF0, 64'h5566_7788_0000_0000};

        repeat (2) @(negedge clk);
        chk_reset_state("in_reset");
        rstn = 1'b1;
        @(negedge clk);
        chk_reset_state("post_reset");

        for (int i = 0; i < 17; i++) do_op(tbl[i], i % 3, (i * 2) % 3);

        // Long stall on both channels, with stray responses while in REQ.
        do_op(tbl[14], 4, 3);
        // Back-to-back ld then sd at minimum latency.
        do_op(tbl[14], 0, 0);
        do_op(tbl[15], 0, 0);

        // Reset in WAIT, followed by a response that must be discarded.
        req_if.req_valid  = 1'b1;
        req_if.req_we     = 1'b0;
        req_if.req_funct3 = 3'b011;
        req_if.req_addr   = 64'h18;
        req_if.req_rd     = 5'd3;
        @(negedge clk);
        req_if.req_valid     = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        @(negedge clk);
        mem_if.mem_req_ready = 1'b0;
        chk("wait_before_reset", mem_if.mem_req_valid, 0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
        chk_reset_state("rst_wait_a");
        @(negedge clk);
        mem_if.mem_rsp_valid = 1'b0;
        chk_reset_state("rst_wait_b");
        @(negedge clk);
        chk_reset_state("rst_wait_c");
        last_ld = '0;

        for (int i = 0; i < 80; i++) begin
            logic [63:0] a;
            a = {32'h0, $urandom};
            do_op(make_vec(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                           {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the NPC core. Accepts one memory operation per transaction from the execute stage and drives a 64-bit data-memory port with a valid/ready request channel and a response channel. For loads it returns the byte-lane-extracted, sign/zero-extended result directly on the general-purpose register file's load write-back inputs (`wb_en`, `wb_load`, `wb_addr`, `load_data`). One operation is in flight at a time.

## Interface
- `DW`, 64: data width; also the memory bus data width.
- `AW`, 5: register address width.
- `clk`  in  1  clock; all state updates on posedge.
- `rstn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  execute stage presents an operation.
- `req_ready`  out  1  LSU can accept; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV64 size/sign code.
- `req_addr`  in  DW  effective byte address.
- `req_wdata`  in  DW  store data, rs2 value.
- `req_rd`  in  AW  load destination register.
- `mem_req_valid`  out  1  memory request.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_we`, `mem_addr[DW-1:0]`, `mem_wdata[DW-1:0]`, `mem_wmask[7:0]`  out  request fields; `mem_addr` is 8-byte aligned (`[2:0]`=0).
- `mem_rsp_valid`  in  1  response/ack; `mem_rdata[DW-1:0]` in, valid with it.
- `wb_en`, `wb_load`  out  1  load write-back strobe, both high together.
- `wb_addr`  out  AW  latched `req_rd`.
- `load_data`  out  DW  extended load result.
- `done`  out  1  one-cycle pulse on completion of any op, including errors.
- `err_misalign`  out  1  one-cycle pulse, together with `done`, on misaligned or illegal op.

## Operation
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE: `req_ready`=1. On `req_valid`, latch all req fields. If aligned and legal, go to REQ; otherwise go to ERR.
- Legal loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. Legal stores: 000 sb, 001 sh, 010 sw, 011 sd. All other codes are illegal and go to ERR.
- Alignment: the address must be a multiple of the access size (1/2/4/8 bytes).
- REQ: `mem_req_valid`=1 with fields held stable until `mem_req_ready`, then go to WAIT.
- Store lanes: `off`=`addr[2:0]`; `mem_wdata`=`req_wdata << (8*off)`; `mem_wmask`=size mask (0x01/0x03/0x0F/0xFF) `<< off`. For loads, `mem_wmask`=0.
- WAIT: on `mem_rsp_valid`, compute `mem_rdata >> (8*off)`, truncate to size, then sign- or zero-extend to DW. Register the result into `load_data` (loads only) and go to DONE. Stores use `mem_rsp_valid` as the write ack.
- DONE: `done`=1. For a load, `wb_en`=`wb_load`=1. The next state is IDLE, and a new request is accepted no earlier than the following cycle.
- ERR: `done`=`err_misalign`=1; no memory access and no write-back; next state is IDLE.
- Loads to rd=0 still assert `wb_en`; the register file masks reads of x0.
- `mem_rsp_valid` outside WAIT is ignored.

## Timing
- Reset: state IDLE; `req_ready`=1; `mem_req_valid`, `mem_we`, `wb_en`, `wb_load`, `done`, `err_misalign`=0; `mem_addr`, `mem_wdata`, `mem_wmask`, `wb_addr`, `load_data`=0.
- Minimum latency, accept to `done`, is 3 cycles: accept edge → REQ, with same-cycle ready → WAIT, with same-cycle rsp → DONE. The error path takes 1 cycle.
- All outputs are registered or decoded from state only; there is no combinational path from `mem_*` inputs to outputs.
- Write-back fields are stable for the whole DONE cycle, so the register file can capture them on the negedge inside that cycle.
- Reset asserted in any state returns to IDLE at the next edge. It drops `mem_req_valid` even mid-handshake, and a response arriving afterwards is discarded.

## Structure
- Package `lsu_pkg` holds the funct3 encoding constants, the state enum, and size masks.
- Sub-module `lsu_align` is purely combinational. It computes the store shift and mask from (`funct3`, `off`, `wdata`) and load extraction/extension from (`funct3`, `off`, `rdata`), and is instantiated once.

## Test plan
- Load lb, addr 0x...1003, `mem_rdata`=0x8877_6655_4433_2211 → `load_data`=0x0000_0000_0000_0044; same with a byte of 0x88 at off 7 → 0xFFFF_FFFF_FFFF_FF88. lbu with the 0x88 byte → 0x88.
- Store sh, addr 0x...0006, `wdata`=0xABCD → `mem_addr` low 3 bits = 0, `mem_wmask`=0xC0, `mem_wdata`=0xABCD_0000_0000_0000; `done` with no `wb_en`.
- lw at addr 0x...0002 → `err_misalign` and `done` 1 cycle after accept, `mem_req_valid` never asserts. funct3=111 load → same response.
- `mem_req_ready` held low 4 cycles, then rsp delayed 3 cycles → request fields stable throughout, `req_ready`=0, a single `done`.
- `rstn` low while in WAIT, then a spurious `mem_rsp_valid` → IDLE, no `wb_en`, all outputs at reset values.
- Back-to-back ld then sd → each fully sequenced; ld returns the full 64-bit `mem_rdata`, `wb_addr` equals its rd.
